context_scheduler: RTL

- Hardware round-robin time-slice scheduler for the 4-context processor.
- Counts a quantum, picks the next eligible process ID, and requests a context change from the processor core.
- Holds the request until the core acknowledges that it performed the switch.
- Acts as the requesting side of the core's Change_Context / Proc_ID mechanism.

---
 rtl/context_scheduler.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/context_scheduler.sv
// ---------------------------------------------------------------------------
// context_scheduler
//
// Round-robin time-slice scheduler for the 4-context processor. It counts a
// quantum, picks the next eligible process ID and raises a context-change
// request toward the core. The request is held until the core acknowledges it.
//
// Optional build macro: SCHED_ACK_TIMEOUT_EN
//   When defined, an unanswered request is abandoned after 255 cycles and the
//   sticky Ack_Timeout flag is raised. When undefined, REQ waits indefinitely
//   and the Ack_Timeout port does not exist.
//
// Ports:
//   Slow_Clock    in   processor clock, rising-edge state updates
//   Reset_N       in   synchronous active-low reset
//   Enable        in   scheduler enable; low stops new preemptions
//   Quantum       in   slice length in cycles (0 behaves as 1)
//   Ready_Mask    in   per-process runnable flags
//   Cur_Proc_ID   in   process currently running in the core
//   Proc_Done     in   pulse: current process halted (early yield)
//   Clear_Done    in   clears Done_Mask, wins over Proc_Done
//   Preempt_Ack   in   core performed the context change
//   Preempt_Req   out  request to switch to Next_Proc_ID
//   Next_Proc_ID  out  target context
//   Timer_Value   out  remaining cycles in the current slice
//   Done_Mask     out  sticky per-process halted flags
//   All_Done      out  no eligible process remains
//   Ack_Timeout   out  (macro only) sticky request-timeout flag
//   Switch_Count  out  number of acknowledged switches (wraps)
// ---------------------------------------------------------------------------
module context_scheduler #(
  parameter int NUM_PROCS = 4,
  parameter int QUANTUM_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 Slow_Clock,
  input  logic                 Reset_N,
  input  logic                 Enable,
  input  logic [QUANTUM_W-1:0] Quantum,
  input  logic [NUM_PROCS-1:0] Ready_Mask,
  input  logic [1:0]           Cur_Proc_ID,
  input  logic                 Proc_Done,
  input  logic                 Clear_Done,
  input  logic                 Preempt_Ack,
  output logic                 Preempt_Req,
  output logic [1:0]           Next_Proc_ID,
  output logic [QUANTUM_W-1:0] Timer_Value,
  output logic [NUM_PROCS-1:0] Done_Mask,
  output logic                 All_Done,
`ifdef SCHED_ACK_TIMEOUT_EN
  output logic                 Ack_Timeout,
`endif
  output logic [CNT_W-1:0]     Switch_Count
);

  localparam int ID_W = 2;

  typedef enum logic [2:0] {IDLE, COUNT, SELECT, REQ, HALTED} state_t;

  state_t               state, state_n;
  logic [QUANTUM_W-1:0] timer_n, q_load;
  logic [ID_W-1:0]      next_id_n, win_id, cand_id;
  logic                 win_found;
  logic [NUM_PROCS-1:0] elig, done_n;
  logic                 all_done_n;
  logic [CNT_W-1:0]     sw_cnt_n;
`ifdef SCHED_ACK_TIMEOUT_EN
  logic [7:0]           to_cnt, to_cnt_n;
  logic                 ack_to_n;
`endif

  assign q_load      = (Quantum == '0) ? QUANTUM_W'(1) : Quantum;
  assign elig        = Ready_Mask & ~Done_Mask;
  assign Preempt_Req = (state == REQ);

  // Round-robin search starting one past the running process; the running
  // process itself is never a winner (handled separately in SELECT).
  always_comb begin
    win_found = 1'b0;
    win_id    = Cur_Proc_ID;
    cand_id   = '0;
    for (int k = 1; k < NUM_PROCS; k++) begin
      cand_id = ID_W'((int'(Cur_Proc_ID) + k) % NUM_PROCS);
      if (!win_found && elig[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = Timer_Value;
    next_id_n  = Next_Proc_ID;
    all_done_n = All_Done;
    sw_cnt_n   = Switch_Count;
    done_n     = Done_Mask;
`ifdef SCHED_ACK_TIMEOUT_EN
    to_cnt_n   = to_cnt;
    ack_to_n   = Ack_Timeout;
`endif

    if (Clear_Done)
      done_n = '0;
    else if (Proc_Done)
      done_n[Cur_Proc_ID] = 1'b1;

    case (state)
      IDLE: begin
        if (Enable) begin
          timer_n = q_load;
          state_n = COUNT;
        end
      end
      COUNT: begin
        // Disable freezes the timer; re-enabling reloads a fresh slice.
        if (!Enable) begin
          state_n = IDLE;
        end else begin
          timer_n = Timer_Value - QUANTUM_W'(1);
          if (Timer_Value == QUANTUM_W'(1) || Proc_Done)
            state_n = SELECT;
        end
      end
      SELECT: begin
`ifdef SCHED_ACK_TIMEOUT_EN
        to_cnt_n = '0;
`endif
        if (win_found) begin
          next_id_n = win_id;
          state_n   = REQ;
        end else if (elig[Cur_Proc_ID]) begin
          timer_n = q_load;
          state_n = COUNT;
        end else begin
          all_done_n = 1'b1;
          state_n    = HALTED;
        end
      end
      REQ: begin
        if (Preempt_Ack) begin
          sw_cnt_n = Switch_Count + CNT_W'(1);
          timer_n  = q_load;
          state_n  = COUNT;
        end
`ifdef SCHED_ACK_TIMEOUT_EN
        // Counter value 254 on an unacked edge means 255 REQ cycles elapsed.
        else if (to_cnt == 8'd254) begin
          ack_to_n = 1'b1;
          timer_n  = q_load;
          state_n  = COUNT;
        end else begin
          to_cnt_n = to_cnt + 8'd1;
        end
`endif
      end
      HALTED: begin
        if (Clear_Done || (elig != '0)) begin
          all_done_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Slow_Clock) begin
    if (!Reset_N) begin
      state        <= IDLE;
      Timer_Value  <= '0;
      Next_Proc_ID <= '0;
      All_Done     <= 1'b0;
      Switch_Count <= '0;
      Done_Mask    <= '0;
`ifdef SCHED_ACK_TIMEOUT_EN
      to_cnt       <= '0;
      Ack_Timeout  <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      Timer_Value  <= timer_n;
      Next_Proc_ID <= next_id_n;
      All_Done     <= all_done_n;
      Switch_Count <= sw_cnt_n;
      Done_Mask    <= done_n;
`ifdef SCHED_ACK_TIMEOUT_EN
      to_cnt       <= to_cnt_n;
      Ack_Timeout  <= ack_to_n;
`endif
    end
  end

endmodule
